// File: rtl/muldiv_exec_unit_pkg.sv
// Shared encodings for the multiply/divide execute stage; the decode stage reuses them.
package muldiv_exec_unit_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_exec_unit.sv
// RV32M multi-cycle multiply/divide: shift-add multiply and restoring divide on magnitudes,
// fixed latency, result presented to the register file write port for one cycle.
module muldiv_exec_unit
  import muldiv_exec_unit_pkg::*;
#(
  parameter int dataWidth = 32,
  parameter int addWidth  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [dataWidth-1:0] opA,
  input  logic [dataWidth-1:0] opB,
  input  logic [addWidth-1:0]  rdIn,
  output logic                 busy,
  output logic                 done,
  output logic [dataWidth-1:0] result,
  output logic [addWidth-1:0]  rdOut,
  output logic                 wrEn
);

  localparam int W  = dataWidth;
  localparam int CW = $clog2(dataWidth);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg;
  logic [2:0]      op_reg;
  logic [addWidth-1:0] rd_reg;
  logic [W-1:0]    m_reg, hi_reg, lo_reg, result_reg, special_val_reg;
  logic            neg_reg, special_reg;

  // Operand decode at accept time
  logic            a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [W-1:0]    a_mag, b_mag, special_val;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    sa       = a_signed & opA[W-1];
    sb       = b_signed & opB[W-1];
    a_mag    = sa ? -opA : opA;
    b_mag    = sb ? -opB : opB;
    div_zero = op[2] && (opB == '0);
    div_ovf  = (op == OP_DIV || op == OP_REM) && (opA == MIN_NEG) && (opB == '1);
    special_val = '0;
    if (div_zero)
      special_val = op[1] ? opA : '1;
    else if (div_ovf)
      special_val = op[1] ? '0 : MIN_NEG;
  end

  // Single adder/subtractor: multiply accumulate (hi + m) or divide trial ({hi,next bit} - m)
  logic          is_div, add_sub;
  logic [W:0]    add_x, add_y;
  logic [W+1:0]  add_sum;

  assign is_div  = op_reg[2];
  assign add_sub = is_div;
  assign add_x   = is_div ? {hi_reg, lo_reg[W-1]} : {1'b0, hi_reg};
  assign add_y   = {1'b0, m_reg};
  assign add_sum = {1'b0, add_x} + {1'b0, (add_sub ? ~add_y : add_y)} + (W+2)'(add_sub);

  logic [W-1:0]   hi_n, lo_n, quot, rem, mul_res, final_val;
  logic [2*W-1:0] prod, prod_s;

  always_comb begin
    if (is_div) begin
      // carry out of the subtract means the trial did not borrow
      if (add_sum[W+1]) begin
        hi_n = add_sum[W-1:0];
        lo_n = {lo_reg[W-2:0], 1'b1};
      end else begin
        hi_n = {hi_reg[W-2:0], lo_reg[W-1]};
        lo_n = {lo_reg[W-2:0], 1'b0};
      end
    end else begin
      if (lo_reg[0])
        {hi_n, lo_n} = {add_sum[W:0], lo_reg[W-1:1]};
      else
        {hi_n, lo_n} = {1'b0, hi_reg, lo_reg[W-1:1]};
    end
    prod      = {hi_n, lo_n};
    prod_s    = neg_reg ? -prod : prod;
    mul_res   = (op_reg == OP_MUL) ? prod_s[W-1:0] : prod_s[2*W-1:W];
    quot      = neg_reg ? -lo_n : lo_n;
    rem       = neg_reg ? -hi_n : hi_n;
    final_val = special_reg ? special_val_reg :
                (!is_div ? mul_res : (op_reg[1] ? rem : quot));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (count_reg == CW'(W-1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      op_reg          <= '0;
      rd_reg          <= '0;
      m_reg           <= '0;
      hi_reg          <= '0;
      lo_reg          <= '0;
      result_reg      <= '0;
      special_val_reg <= '0;
      neg_reg         <= 1'b0;
      special_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (start) begin
          op_reg          <= op;
          rd_reg          <= rdIn;
          count_reg       <= '0;
          hi_reg          <= '0;
          // multiply: lo holds multiplier, m multiplicand; divide: lo dividend, m divisor
          lo_reg          <= op[2] ? a_mag : b_mag;
          m_reg           <= op[2] ? b_mag : a_mag;
          neg_reg         <= (op[2] & op[1]) ? sa : (sa ^ sb);
          special_reg     <= div_zero | div_ovf;
          special_val_reg <= special_val;
        end
        CALC: begin
          hi_reg    <= hi_n;
          lo_reg    <= lo_n;
          count_reg <= count_reg + CW'(1);
          if (count_reg == CW'(W-1))
            result_reg <= final_val;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign wrEn   = done;
  assign result = result_reg;
  assign rdOut  = rd_reg;

endmodule

// File: tb/tb_muldiv_exec_unit.sv
// Scoreboard bench for muldiv_exec_unit: directed RV32M corner cases, start spamming,
// mid-operation reset and randomized operations against a behavioural reference.
module tb_muldiv_exec_unit;

  logic        clk;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] opA, opB, result;
  logic [4:0]  rdIn, rdOut;
  logic        busy, done, wrEn;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  muldiv_exec_unit #(.dataWidth(32), .addWidth(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .rdIn(rdIn), .busy(busy), .done(done), .result(result), .rdOut(rdOut), .wrEn(wrEn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] as, bs;
    logic [63:0]        au, bu, p;
    logic signed [31:0] sa32, sb32;
    as = {{32{a[31]}}, a};
    bs = {{32{b[31]}}, b};
    au = {32'd0, a};
    bu = {32'd0, b};
    sa32 = a;
    sb32 = b;
    p = '0;
    case (o)
      3'd0: begin p = au * bu; return p[31:0]; end
      3'd1: begin p = as * bs; return p[63:32]; end
      3'd2: begin p = as * $signed(bu); return p[63:32]; end
      3'd3: begin p = au * bu; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sa32 / sb32);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'(sa32 % sb32);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the first IDLE cycle after done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit spam);
    exp_t e;
    int   cyc;
    int   extra;
    sb_q.push_back('{res: exp, rd: rd});
    start = 1'b1; op = o; opA = a; opB = b; rdIn = rd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (spam) begin
        op = 3'($urandom_range(7)); opA = $urandom; opB = $urandom; rdIn = rd + 5'd1;
      end else begin
        start = 1'b0;
      end
    end while (!done && cyc < 100);
    chk("latency", 32'(cyc), 32'd33);
    e = sb_q.pop_front();
    chk("result", result, e.res);
    chk("rdOut", 32'(rdOut), 32'(e.rd));
    chk("wrEn", 32'(wrEn), 32'd1);
    $display("op=%0d a=%h b=%h rd=%0d -> result=%h (exp %h) cycles=%0d", o, a, b, rd, result, e.res, cyc);
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    if (spam) begin
      extra = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk("spam_extra_done", 32'(extra), 32'd0);
      chk("spam_rd_held", 32'(rdOut), 32'(rd));
    end
  endtask

  initial begin
    int          dones;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; op = '0; opA = '0; opB = '0; rdIn = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wrEn", 32'(wrEn), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rdOut", 32'(rdOut), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0);
    run_op(3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 1'b0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 1'b0);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 1'b0);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 1'b0);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 1'b0);
    run_op(3'd5, 32'd100,      32'd7,        5'd7,  32'd14,       1'b0);
    run_op(3'd7, 32'd100,      32'd7,        5'd8,  32'd2,        1'b0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1'b0);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,        1'b0);
    run_op(3'd5, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1'b0);
    run_op(3'd7, 32'd5,        32'd0,        5'd13, 32'd5,        1'b0);
    run_op(3'd4, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1'b0);
    run_op(3'd6, 32'hFFFFFFFB, 32'd0,        5'd15, 32'hFFFFFFFB, 1'b0);
    run_op(3'd0, 32'd3,        32'd4,        5'd0,  32'd12,       1'b0);

    // start held high through CALC and DONE: exactly one completion
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd20, 32'hFFFFFFEB, 1'b1);

    // reset in the middle of a divide
    start = 1'b1; op = 3'd4; opA = 32'd1000; opB = 32'd3; rdIn = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rdOut", 32'(rdOut), 32'd0);
    dones = 0;
    repeat (50) begin
      @(negedge clk);
      if (done || wrEn) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    $display("mid-op reset: busy=%0d done pulses=%0d", busy, dones);
    run_op(3'd5, 32'd1000, 32'd3, 5'd9, 32'd333, 1'b0);

    repeat (8) begin
      ro = 3'($urandom_range(7));
      ra = $urandom;
      rb = ($urandom_range(3) == 0) ? 32'($urandom_range(5)) : $urandom;
      run_op(ro, ra, rb, 5'($urandom_range(31)), ref_op(ro, ra, rb), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
